// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter FSM states, filter width, default timing, command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RTS   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } tx_state_t;

  localparam int unsigned FILTER_W        = 8;
  localparam int unsigned INHIBIT_DEFAULT = 5000;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

endpackage

// File: rtl/ps2_host_tx_if.sv
// Pin and handshake bundle for the PS/2 host transmitter.
// The err flag is present only when PS2_TX_TIMEOUT_EN is defined.
interface ps2_host_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2_c;
  logic       data_in;
  logic       ps2c_drive;
  logic       ps2d_drive;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_ok;
`ifdef PS2_TX_TIMEOUT_EN
  logic       err;
`endif

  modport master (
    output wr_ps2, din, ps2_c, data_in,
    input  ps2c_drive, ps2d_drive, tx_idle, tx_done_tick, ack_ok
`ifdef PS2_TX_TIMEOUT_EN
    , input err
`endif
  );

  modport slave (
    input  wr_ps2, din, ps2_c, data_in,
    output ps2c_drive, ps2d_drive, tx_idle, tx_done_tick, ack_ok
`ifdef PS2_TX_TIMEOUT_EN
    , output err
`endif
  );
endinterface

// File: rtl/ps2_edge_filter.sv
// PS/2 clock debounce: the level flips only after FILTER_W identical samples;
// fall_edge marks the cycle in which the filtered level is about to go low.
module ps2_edge_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ps2_c,
  output logic fall_edge,
  output logic level
);

  logic [FILTER_W-1:0] filt_q;
  logic [FILTER_W-1:0] filt_d;
  logic                level_d;

  always_comb begin
    filt_d  = {ps2_c, filt_q[FILTER_W-1:1]};
    level_d = level;
    if (filt_d == '1)
      level_d = 1'b1;
    else if (filt_d == '0)
      level_d = 1'b0;
  end

  assign fall_edge = level & ~level_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= '0;
      level  <= 1'b0;
    end else begin
      filt_q <= filt_d;
      level  <= level_d;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits, odd parity, stop, ack sample.
// Optional device-clock watchdog and err flag with PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_DEFAULT
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic            clk,
  input  logic            rst,
  ps2_host_tx_if.slave    bus
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);

  tx_state_t       state, state_next;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic            ack_q, ack_d;
  logic [1:0]      sync_q;
  logic            fall_edge;
  logic            level;

  ps2_edge_filter u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_c     (bus.ps2_c),
    .fall_edge (fall_edge),
    .level     (level)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  assign bus.err = err_q;
`endif

  always_comb begin
    state_next       = state;
    shift_d          = shift_q;
    bit_d            = bit_q;
    inh_d            = inh_q;
    ack_d            = ack_q;
    bus.ps2c_drive   = 1'b0;
    bus.ps2d_drive   = 1'b0;
    bus.tx_idle      = 1'b0;
    bus.tx_done_tick = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d  = '0;
    err_d = err_q;
`endif
    case (state)
      S_IDLE: begin
        bus.tx_idle = 1'b1;
        if (bus.wr_ps2) begin
          shift_d    = {~^bus.din, bus.din};
          inh_d      = '0;
          ack_d      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
          err_d      = 1'b0;
`endif
          state_next = S_RTS;
        end
      end
      S_RTS: begin
        bus.ps2c_drive = 1'b1;
        if (inh_q == IW'(INHIBIT_CYCLES - 1))
          state_next = S_START;
        else
          inh_d = inh_q + 1'b1;
      end
      S_START: begin
        bus.ps2d_drive = 1'b1;
        if (fall_edge) begin
          bit_d      = 4'd8;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        bus.ps2d_drive = ~shift_q[0];
        if (fall_edge) begin
          shift_d = {1'b0, shift_q[8:1]};
          if (bit_q == 4'd0)
            state_next = S_STOP;
          else
            bit_d = bit_q - 1'b1;
        end
      end
      S_STOP: begin
        if (fall_edge) begin
          ack_d      = ~sync_q[1];
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.tx_done_tick = 1'b1;
        state_next       = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Abort rides the normal DONE path so the tick and release happen exactly as for a finished frame.
    if ((state == S_START || state == S_DATA || state == S_STOP) && !fall_edge) begin
      if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
        err_d      = 1'b1;
        ack_d      = 1'b0;
        state_next = S_DONE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  assign bus.ack_ok = ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      inh_q   <= '0;
      ack_q   <= 1'b0;
      sync_q  <= '0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      inh_q   <= inh_d;
      ack_q   <= ack_d;
      sync_q  <= {sync_q[0], bus.data_in};
`ifdef PS2_TX_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
